// File: rtl/uart_calc_pkg.sv
// Shared constants and types for the UART calculator core.
package uart_calc_pkg;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_MUL   = 8'h2A;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_E     = 8'h45;

  localparam int RES_W      = 21;  // signed result, -999 .. 998001
  localparam int OPND_W     = 10;  // operand 0 .. 999
  localparam int BIN_W      = 20;  // magnitude fed to the BCD converter
  localparam int BCD_DIGITS = 6;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int BUF_N      = 9;   // '-' + 6 digits + CR + LF

  typedef enum logic [2:0] {
    ST_OPA,
    ST_OPB,
    ST_CALC,
    ST_CONV,
    ST_SEND,
    ST_GAP,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASC_0) && (c <= ASC_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == ASC_PLUS) || (c == ASC_MINUS) || (c == ASC_MUL);
  endfunction

  function automatic op_t to_op(input logic [7:0] c);
    if (c == ASC_MINUS) return OP_SUB;
    if (c == ASC_MUL)   return OP_MUL;
    return OP_ADD;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble: 20-bit binary to 6 BCD digits.
// The first shift happens on the start edge (the add-3 step is a no-op on an
// all-zero BCD register), so o_done rises exactly 20 cycles after i_start.
module bin2bcd
  import uart_calc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  logic [BIN_W-1:0] r_sh;
  logic [BCD_W-1:0] r_bcd;
  logic [4:0]       r_cnt;
  logic             r_run;
  logic [BCD_W-1:0] w_adj;

  // Add 3 to every nibble that is 5 or more, ahead of the next shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift with a down-counter until terminal count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_bcd <= BCD_W'(i_bin[BIN_W-1]);
      r_sh  <= i_bin << 1;
      r_cnt <= 5'(BIN_W - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == 5'd0) begin
        r_run <= 1'b0;
      end else begin
        r_bcd <= BCD_W'({w_adj, r_sh[BIN_W-1]});
        r_sh  <= r_sh << 1;
        r_cnt <= r_cnt - 5'd1;
      end
    end
  end

  assign o_bcd  = r_bcd;
  assign o_done = r_run && (r_cnt == 5'd0);

endmodule

// File: rtl/uart_calc_core.sv
// ASCII calculator between UART RX and TX: parses <A><op><B>=, replies with
// the decimal result plus CR LF, pacing TX bytes with an internal gap timer.
//
// state | meaning
// OPA   | collecting operand A digits, waiting for operator
// OPB   | collecting operand B digits, waiting for '='
// CALC  | one cycle: ALU result captured, BCD conversion started
// CONV  | waiting for the double-dabble to finish
// SEND  | tx_valid high for the current buffer byte
// GAP   | TX_GAP-1 cycle spacing after each byte
// ERR   | load "E",CR,LF into the output buffer
module uart_calc_core
  import uart_calc_pkg::*;
#(
  parameter int BIT_CYCLES = 15,
  parameter int TX_GAP     = 10 * BIT_CYCLES + 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_busy
);

  localparam int GAP_W = $clog2(TX_GAP);

  state_t             r_state, w_state_nxt;
  logic [OPND_W-1:0]  r_a, r_b;
  logic [1:0]         r_acnt, r_bcnt;
  op_t                r_op;
  logic               r_neg;
  logic [7:0]         r_buf [BUF_N];
  logic [3:0]         r_len, r_ptr;
  logic [7:0]         r_last;
  logic [GAP_W-1:0]   r_gap;

  logic               w_acc_a, w_acc_b, w_store_op, w_load_res, w_load_err;
  logic               w_next_byte, w_clr, w_last, w_is_digit, w_is_op, w_done;
  logic [3:0]         w_digit;
  logic signed [RES_W-1:0] w_res;
  logic [BIN_W-1:0]   w_mag;
  logic [BCD_W-1:0]   w_bcd;
  logic [7:0]         w_fmt [BUF_N];
  logic [3:0]         w_fmt_len, w_idx, w_nib;
  logic               w_lead;

  assign w_is_digit = is_digit(i_rx_data);
  assign w_is_op    = is_op(i_rx_data);
  assign w_digit    = 4'(i_rx_data - ASC_0);
  assign w_last     = (r_ptr == r_len - 4'd1);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_OPA;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_acc_a     = 1'b0;
    w_acc_b     = 1'b0;
    w_store_op  = 1'b0;
    w_load_res  = 1'b0;
    w_load_err  = 1'b0;
    w_next_byte = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      ST_OPA: if (i_rx_valid && i_rx_data != ASC_SP) begin
        if (w_is_digit && r_acnt != 2'd3)     w_acc_a = 1'b1;
        else if (w_is_op && r_acnt != 2'd0) begin
          w_store_op  = 1'b1;
          w_state_nxt = ST_OPB;
        end else                              w_state_nxt = ST_ERR;
      end
      ST_OPB: if (i_rx_valid && i_rx_data != ASC_SP) begin
        if (w_is_digit && r_bcnt != 2'd3)                  w_acc_b = 1'b1;
        else if (i_rx_data == ASC_EQ && r_bcnt != 2'd0)    w_state_nxt = ST_CALC;
        else                                               w_state_nxt = ST_ERR;
      end
      ST_CALC: w_state_nxt = ST_CONV;
      ST_CONV: if (w_done) begin
        w_load_res  = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_ERR: begin
        w_load_err  = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: w_state_nxt = ST_GAP;
      ST_GAP: if (r_gap == '0) begin
        if (w_last) begin
          w_clr       = 1'b1;
          w_state_nxt = ST_OPA;
        end else begin
          w_next_byte = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      default: w_state_nxt = ST_OPA;
    endcase
  end

  // ALU: operands are unsigned, so only subtraction can go negative
  always_comb begin
    w_res = '0;
    unique case (r_op)
      OP_ADD:  w_res = RES_W'(r_a) + RES_W'(r_b);
      OP_SUB:  w_res = RES_W'(r_a) - RES_W'(r_b);
      OP_MUL:  w_res = RES_W'(r_a) * RES_W'(r_b);
      default: w_res = '0;
    endcase
  end

  assign w_mag = w_res[RES_W-1] ? BIN_W'(-w_res) : BIN_W'(w_res);

  bin2bcd u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (r_state == ST_CALC),
    .i_bin   (w_mag),
    .o_bcd   (w_bcd),
    .o_done  (w_done)
  );

  // Format sign, digits without leading zeros, CR, LF
  always_comb begin
    for (int i = 0; i < BUF_N; i++) w_fmt[i] = 8'h00;
    w_idx  = 4'd0;
    w_lead = 1'b0;
    w_nib  = 4'd0;
    if (r_neg) begin
      w_fmt[0] = ASC_MINUS;
      w_idx    = 4'd1;
    end
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      w_nib = w_bcd[4*i +: 4];
      if (w_lead || w_nib != 4'd0 || i == 0) begin
        w_lead       = 1'b1;
        w_fmt[w_idx] = ASC_0 + {4'h0, w_nib};
        w_idx        = w_idx + 4'd1;
      end
    end
    w_fmt[w_idx]        = ASC_CR;
    w_fmt[w_idx + 4'd1] = ASC_LF;
    w_fmt_len           = w_idx + 4'd2;
  end

  // Operand accumulation, output buffer, byte pointer and gap down-counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acnt <= '0;
      r_bcnt <= '0;
      r_op   <= OP_ADD;
      r_neg  <= 1'b0;
      r_len  <= '0;
      r_ptr  <= '0;
      r_last <= '0;
      r_gap  <= '0;
      for (int i = 0; i < BUF_N; i++) r_buf[i] <= '0;
    end else begin
      if (w_clr) begin
        r_a    <= '0;
        r_b    <= '0;
        r_acnt <= '0;
        r_bcnt <= '0;
        r_op   <= OP_ADD;
      end
      if (w_acc_a) begin
        r_a    <= OPND_W'(r_a * 10 + w_digit);
        r_acnt <= r_acnt + 2'd1;
      end
      if (w_acc_b) begin
        r_b    <= OPND_W'(r_b * 10 + w_digit);
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (w_store_op) r_op <= to_op(i_rx_data);
      if (r_state == ST_CALC) r_neg <= w_res[RES_W-1];
      if (w_load_res) begin
        r_buf <= w_fmt;
        r_len <= w_fmt_len;
        r_ptr <= '0;
      end
      if (w_load_err) begin
        r_buf[0] <= ASC_E;
        r_buf[1] <= ASC_CR;
        r_buf[2] <= ASC_LF;
        r_len    <= 4'd3;
        r_ptr    <= '0;
      end
      if (r_state == ST_SEND) begin
        r_last <= r_buf[r_ptr];
        r_gap  <= GAP_W'(TX_GAP - 2);
      end else if (r_state == ST_GAP && r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
      if (w_next_byte) r_ptr <= r_ptr + 4'd1;
    end
  end

  // tx_data shows the live byte during SEND and holds it afterwards
  assign o_tx_valid = (r_state == ST_SEND);
  assign o_tx_data  = (r_state == ST_SEND) ? r_buf[r_ptr] : r_last;
  assign o_busy     = (r_state == ST_CALC) || (r_state == ST_CONV) ||
                      (r_state == ST_SEND) || (r_state == ST_GAP);

endmodule

// File: tb/tb_uart_calc_core.sv
// Scoreboard bench for uart_calc_core: expressions are driven byte by byte,
// expected replies are queued from integer arithmetic, a monitor checks them.
module tb_uart_calc_core;

  localparam int BIT_CYCLES = 15;
  localparam int TX_GAP     = 10 * BIT_CYCLES + 2;
  localparam int CALC_LAT   = 22;
  localparam int ERR_LAT    = 2;
  localparam int IDLE_BOUND = 3000;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  uart_calc_core #(.BIT_CYCLES(BIT_CYCLES), .TX_GAP(TX_GAP)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    logic [7:0] b;
    int         c;   // required cycle, or -1 for "one TX_GAP after previous"
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks    = 0;
  int         failures  = 0;
  int         last_tx   = -100000;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pop and compare on every tx_valid; tx_data must hold otherwise
  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx actual=%02h required=none cyc=%0d", tx_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("tx_data", tx_data, mon_e.b);
        if (mon_e.c >= 0) check("first_tx_cycle", cyc, mon_e.c);
        else              check("tx_spacing", cyc - last_tx, TX_GAP);
      end
      last_tx = cyc;
    end else if (!rst_q) begin
      check("tx_data_hold", tx_data, prev_data);
    end
    prev_data = tx_data;
  end

  task automatic send_byte(input logic [7:0] b, output int t);
    rx_data  = b;
    rx_valid = 1'b1;
    t        = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s, input int gap_max, output int t_last);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], t_last);
      if (i != s.len() - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic push_resp(input string s, input int first_cyc);
    for (int i = 0; i < s.len(); i++) sb.push_back('{b: s[i], c: (i == 0) ? first_cyc : -1});
    sb.push_back('{b: 8'h0D, c: -1});
    sb.push_back('{b: 8'h0A, c: -1});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy !== 1'b0) && n < IDLE_BOUND) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n >= IDLE_BOUND) ? 1 : 0, 0);
    if (n >= IDLE_BOUND) sb.delete();
  endtask

  task automatic run_case(input string stim, input string resp, input int lat, input int gap_max);
    int t;
    send_str(stim, gap_max, t);
    push_resp(resp, t + lat);
    wait_idle();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  function automatic string rand_operand(output int v);
    string s = "";
    int    n = $urandom_range(1, 3);
    v = 0;
    for (int i = 0; i < n; i++) begin
      int d = $urandom_range(0, 9);
      v = v * 10 + d;
      s = {s, $sformatf("%0d", d)};
      if ($urandom_range(0, 4) == 0) s = {s, " "};
    end
    return s;
  endfunction

  task automatic rand_valid();
    int    a, b, r, opsel;
    string s;
    s = ($urandom_range(0, 3) == 0) ? " " : "";
    s = {s, rand_operand(a)};
    opsel = $urandom_range(0, 2);
    s = {s, (opsel == 0) ? "+" : (opsel == 1) ? "-" : "*"};
    s = {s, rand_operand(b), "="};
    r = (opsel == 0) ? a + b : (opsel == 1) ? a - b : a * b;
    run_case(s, $sformatf("%0d", r), CALC_LAT, 2);
  endtask

  task automatic rand_error();
    string s;
    int    kind = $urandom_range(0, 5);
    int    d    = $urandom_range(0, 9);
    case (kind)
      0: s = $sformatf("%0d%0d%0d%0d", $urandom_range(1, 9), d, $urandom_range(0, 9), $urandom_range(0, 9));
      1: s = $sformatf("%0d%c", d, 8'($urandom_range(8'h61, 8'h7A)));
      2: s = $sformatf("%0d=", d);
      3: s = $sformatf("%0d+%0d*", d, $urandom_range(0, 9));
      4: s = $sformatf("%0d-=", d);
      default: s = "*";
    endcase
    run_case(s, "E", ERR_LAT, 1);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_data", tx_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run_case("12+34=", "46", CALC_LAT, 0);
    run_case("5 - 9 =", "-4", CALC_LAT, 0);
    run_case("999*999=", "998001", CALC_LAT, 0);
    run_case("0+0=", "0", CALC_LAT, 0);
    run_case("0-999=", "-999", CALC_LAT, 0);
    run_case("1234", "E", ERR_LAT, 0);
    run_case("+", "E", ERR_LAT, 0);
    run_case("12=", "E", ERR_LAT, 0);

    // Byte arriving in the second SEND cycle must be dropped
    send_str("4*5=", 0, t);
    push_resp("20", t + CALC_LAT);
    wait_until(t + CALC_LAT + TX_GAP);
    check("busy_in_send", busy, 1);
    check("tx_valid_in_send", tx_valid, 1);
    send_byte("7", t);
    wait_idle();
    run_case("2*3=", "6", CALC_LAT, 0);

    // Byte arriving in the final GAP cycle must be dropped
    send_str("8+1=", 0, t);
    push_resp("9", t + CALC_LAT);
    t = t + CALC_LAT + 2 * TX_GAP;
    wait_until(t + TX_GAP - 1);
    check("busy_final_gap", busy, 1);
    send_byte("9", t);
    check("busy_after_gap", busy, 0);
    check("final_gap_drained", sb.size(), 0);
    run_case("1+1=", "2", CALC_LAT, 0);

    // Reset in the gap after the second byte of a result
    send_str("12+34=", 0, t);
    sb.push_back('{b: 8'h34, c: t + CALC_LAT});
    sb.push_back('{b: 8'h36, c: -1});
    wait_until(t + CALC_LAT + TX_GAP + 20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_data", tx_data, 0);
    repeat (2 * TX_GAP) @(negedge clk);
    check("rst_no_resume", sb.size(), 0);
    check("rst_idle_busy", busy, 0);
    run_case("1+1=", "2", CALC_LAT, 0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) rand_error();
      else                           rand_valid();
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
